// File: rtl/eth_rx_unpack_if.sv
// Byte-stream, word-stream and frame-status bundle between the Ethernet receive
// path, eth_rx_unpack (slave side) and the surrounding logic (master side).
interface eth_rx_unpack_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  rx_counter;
  logic        rx_last;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        seq_gap;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  modport master (
    output rx_data, rx_valid, rx_counter, rx_last, out_ready,
    input  out_data, out_valid, out_sof, out_eof, frame_ok, frame_err,
           err_code, seq_gap, frame_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid, rx_counter, rx_last, out_ready,
    output out_data, out_valid, out_sof, out_eof, frame_ok, frame_err,
           err_code, seq_gap, frame_cnt, err_cnt
  );
endinterface

// File: rtl/eth_rx_unpack.sv
// Receive unpacker: validates the MAGIC/SEQ/LEN header and packs payload bytes into 32-bit words.
// Define RX_CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
module eth_rx_unpack #(
  parameter logic [15:0] MAGIC     = 16'hA55A,
  parameter int          MAX_WORDS = 256
) (
  input logic            sys_clk,
  input logic            rst_n,
  eth_rx_unpack_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
`ifdef RX_CHECKSUM_EN
    CSUM,
`endif
    DROP
  } state_t;

  localparam logic [2:0] ERR_MAGIC = 3'd1;
  localparam logic [2:0] ERR_LEN   = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;
  localparam logic [2:0] ERR_OVF   = 3'd5;
`ifdef RX_CHECKSUM_EN
  localparam logic [2:0] ERR_CSUM  = 3'd6;
`endif
  localparam logic [2:0] ERR_ABORT = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  hdrCnt_q, hdrCnt_d;
  logic [7:0]  hdrByte_q, hdrByte_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] lastSeq_q, lastSeq_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  wordCnt_q, wordCnt_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] outData_q, outData_d;
  logic        outValid_q, outValid_d;
  logic        outSof_q, outSof_d;
  logic        outEof_q, outEof_d;
  logic        frameOk_q, frameOk_d;
  logic        frameErr_q, frameErr_d;
  logic [2:0]  errCode_q, errCode_d;
  logic        seqGap_q, seqGap_d;
  logic [15:0] frameCnt_q, frameCnt_d;
  logic [15:0] errCnt_q, errCnt_d;
  logic        firstFrame_q, firstFrame_d;
`ifdef RX_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        okEvt;
  logic        errEvt;
  logic [2:0]  errCause;
  logic [15:0] hdrWord;
  logic [9:0]  lastWord;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    hdrCnt_d     = hdrCnt_q;
    hdrByte_d    = hdrByte_q;
    seq_d        = seq_q;
    lastSeq_d    = lastSeq_q;
    len_d        = len_q;
    wordCnt_d    = wordCnt_q;
    byteIdx_d    = byteIdx_q;
    shift_d      = shift_q;
    outData_d    = outData_q;
    outValid_d   = outValid_q;
    outSof_d     = outSof_q;
    outEof_d     = outEof_q;
    errCode_d    = errCode_q;
    frameCnt_d   = frameCnt_q;
    errCnt_d     = errCnt_q;
    firstFrame_d = firstFrame_q;
`ifdef RX_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    okEvt        = 1'b0;
    errEvt       = 1'b0;
    errCause     = 3'd0;
    hdrWord      = {hdrByte_q, bus.rx_data};
    lastWord     = len_q - 10'd1;

    if (outValid_q && bus.out_ready) outValid_d = 1'b0;

    if (bus.rx_valid) begin
      // A zero index always starts a new frame; an unfinished one is aborted.
      if (bus.rx_counter == 10'd0) begin
        if (state_q != IDLE && state_q != DROP) begin
          errEvt   = 1'b1;
          errCause = ERR_ABORT;
        end
        hdrByte_d = bus.rx_data;
        hdrCnt_d  = 3'd1;
        state_d   = HDR;
        if (bus.rx_last) begin
          state_d = IDLE;
          if (!errEvt) begin
            errEvt   = 1'b1;
            errCause = ERR_SHORT;
          end
        end
      end else begin
        case (state_q)
          HDR: begin
            hdrCnt_d = hdrCnt_q + 3'd1;
            case (hdrCnt_q)
              3'd1: if (hdrWord != MAGIC) begin
                errEvt   = 1'b1;
                errCause = ERR_MAGIC;
                state_d  = bus.rx_last ? IDLE : DROP;
              end
              3'd2: seq_d[15:8] = bus.rx_data;
              3'd3: seq_d[7:0]  = bus.rx_data;
              3'd4: hdrByte_d   = bus.rx_data;
              3'd5: begin
                if (hdrWord == 16'd0 || hdrWord > 16'(MAX_WORDS)) begin
                  errEvt   = 1'b1;
                  errCause = ERR_LEN;
                  state_d  = bus.rx_last ? IDLE : DROP;
                end else begin
                  state_d   = PAYLOAD;
                  len_d     = hdrWord[9:0];
                  wordCnt_d = 10'd0;
                  byteIdx_d = 2'd0;
`ifdef RX_CHECKSUM_EN
                  csum_d    = 8'h00;
`endif
                end
              end
              default: ;
            endcase
            if (bus.rx_last && !errEvt) begin
              errEvt   = 1'b1;
              errCause = ERR_SHORT;
              state_d  = IDLE;
            end
          end

          PAYLOAD: begin
            shift_d   = {shift_q[15:0], bus.rx_data};
            byteIdx_d = byteIdx_q + 2'd1;
`ifdef RX_CHECKSUM_EN
            csum_d    = csum_q ^ bus.rx_data;
`endif
            if (byteIdx_q == 2'd3) begin
              // A completed word with the previous one still unaccepted is lost.
              if (outValid_q && !bus.out_ready) begin
                errEvt   = 1'b1;
                errCause = ERR_OVF;
                state_d  = bus.rx_last ? IDLE : DROP;
              end else begin
                outData_d  = {shift_q, bus.rx_data};
                outValid_d = 1'b1;
                outSof_d   = (wordCnt_q == 10'd0);
                outEof_d   = (wordCnt_q == lastWord);
                wordCnt_d  = wordCnt_q + 10'd1;
                if (wordCnt_q == lastWord) begin
`ifdef RX_CHECKSUM_EN
                  if (bus.rx_last) begin
                    errEvt   = 1'b1;
                    errCause = ERR_SHORT;
                    state_d  = IDLE;
                  end else begin
                    state_d = CSUM;
                  end
`else
                  if (bus.rx_last) begin
                    okEvt   = 1'b1;
                    state_d = IDLE;
                  end else begin
                    errEvt   = 1'b1;
                    errCause = ERR_LONG;
                    state_d  = DROP;
                  end
`endif
                end else if (bus.rx_last) begin
                  errEvt   = 1'b1;
                  errCause = ERR_SHORT;
                  state_d  = IDLE;
                end
              end
            end else if (bus.rx_last) begin
              errEvt   = 1'b1;
              errCause = ERR_SHORT;
              state_d  = IDLE;
            end
          end

`ifdef RX_CHECKSUM_EN
          CSUM: begin
            if (!bus.rx_last) begin
              errEvt   = 1'b1;
              errCause = ERR_LONG;
              state_d  = DROP;
            end else begin
              state_d = IDLE;
              if (bus.rx_data == csum_q) begin
                okEvt = 1'b1;
              end else begin
                errEvt   = 1'b1;
                errCause = ERR_CSUM;
              end
            end
          end
`endif

          DROP: if (bus.rx_last) state_d = IDLE;

          default: ;
        endcase
      end
    end

    frameOk_d  = okEvt;
    frameErr_d = errEvt;
    seqGap_d   = okEvt && !firstFrame_q && (seq_q != lastSeq_q + 16'd1);
    if (okEvt) begin
      lastSeq_d    = seq_q;
      firstFrame_d = 1'b0;
      frameCnt_d   = frameCnt_q + 16'd1;
    end
    if (errEvt) begin
      errCode_d = errCause;
      errCnt_d  = errCnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      hdrCnt_q     <= 3'd0;
      hdrByte_q    <= 8'h00;
      seq_q        <= 16'h0000;
      lastSeq_q    <= 16'h0000;
      len_q        <= 10'd0;
      wordCnt_q    <= 10'd0;
      byteIdx_q    <= 2'd0;
      shift_q      <= 24'h000000;
      outData_q    <= 32'h00000000;
      outValid_q   <= 1'b0;
      outSof_q     <= 1'b0;
      outEof_q     <= 1'b0;
      frameOk_q    <= 1'b0;
      frameErr_q   <= 1'b0;
      errCode_q    <= 3'd0;
      seqGap_q     <= 1'b0;
      frameCnt_q   <= 16'h0000;
      errCnt_q     <= 16'h0000;
      firstFrame_q <= 1'b1;
`ifdef RX_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      hdrCnt_q     <= hdrCnt_d;
      hdrByte_q    <= hdrByte_d;
      seq_q        <= seq_d;
      lastSeq_q    <= lastSeq_d;
      len_q        <= len_d;
      wordCnt_q    <= wordCnt_d;
      byteIdx_q    <= byteIdx_d;
      shift_q      <= shift_d;
      outData_q    <= outData_d;
      outValid_q   <= outValid_d;
      outSof_q     <= outSof_d;
      outEof_q     <= outEof_d;
      frameOk_q    <= frameOk_d;
      frameErr_q   <= frameErr_d;
      errCode_q    <= errCode_d;
      seqGap_q     <= seqGap_d;
      frameCnt_q   <= frameCnt_d;
      errCnt_q     <= errCnt_d;
      firstFrame_q <= firstFrame_d;
`ifdef RX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_sof   = outSof_q;
  assign bus.out_eof   = outEof_q;
  assign bus.frame_ok  = frameOk_q;
  assign bus.frame_err = frameErr_q;
  assign bus.err_code  = errCode_q;
  assign bus.seq_gap   = seqGap_q;
  assign bus.frame_cnt = frameCnt_q;
  assign bus.err_cnt   = errCnt_q;

endmodule

// File: tb/tb_eth_rx_unpack.sv
// Directed bench for eth_rx_unpack: good frames, sequence gap, header, length,
// short/long, overflow and restart cases, with checksum bytes when RX_CHECKSUM_EN is defined.
module tb_eth_rx_unpack;

`ifdef RX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          fails  = 0;
  logic [33:0] outQ[$];

  eth_rx_unpack_if bus ();

  eth_rx_unpack #(.MAGIC(16'hA55A), .MAX_WORDS(256)) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Record every accepted word as {sof, eof, data}, sampled mid-cycle.
  always begin
    @(negedge sys_clk);
    #2;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      outQ.push_back({bus.out_sof, bus.out_eof, bus.out_data});
  end

  task automatic sendByte(input logic [7:0] d, input logic [9:0] c, input logic l);
    @(negedge sys_clk);
    bus.rx_valid   = 1'b1;
    bus.rx_data    = d;
    bus.rx_counter = c;
    bus.rx_last    = l;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
    end
  endtask

  task automatic sendHeader(input logic [15:0] m, input logic [15:0] s, input logic [15:0] len);
    sendByte(m[15:8], 10'd0, 1'b0);
    sendByte(m[7:0], 10'd1, 1'b0);
    sendByte(s[15:8], 10'd2, 1'b0);
    sendByte(s[7:0], 10'd3, 1'b0);
    sendByte(len[15:8], 10'd4, 1'b0);
    sendByte(len[7:0], 10'd5, 1'b0);
  endtask

  // Payload bytes first, first+1, ...; rx_last on the final byte, or on the checksum byte.
  task automatic sendPayload(input logic [7:0] first, input int n, input logic withCsum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      x = x ^ b;
      sendByte(b, 10'(6 + i), (i == n - 1) && !(withCsum && CSUM_EN));
    end
    if (withCsum && CSUM_EN) sendByte(x, 10'(6 + n), 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    idleCycles(3);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_sof !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_sof: got %b want 0", bus.out_sof); end
    checks++; if (bus.out_eof !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_eof: got %b want 0", bus.out_eof); end
    checks++; if (bus.frame_ok !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_ok: got %b want 0", bus.frame_ok); end
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.err_code !== 3'd0) begin fails++; $display("[TB] FAIL reset_err_code: got %0d want 0", bus.err_code); end
    checks++; if (bus.seq_gap !== 1'b0) begin fails++; $display("[TB] FAIL reset_seq_gap: got %b want 0", bus.seq_gap); end
    checks++; if (bus.frame_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    checks++; if (bus.err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    rst_n = 1'b1;
    idleCycles(2);
  endtask

  task automatic test_good_frame;
    outQ.delete();
    bus.out_ready = 1'b1;
    sendHeader(16'hA55A, 16'h0005, 16'h0002);
    sendPayload(8'h01, 8, 1'b1);
    idleCycles(1);
    checks++; if (bus.frame_ok !== 1'b1) begin fails++; $display("[TB] FAIL good_frame_ok: got %b want 1", bus.frame_ok); end
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("[TB] FAIL good_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.seq_gap !== 1'b0) begin fails++; $display("[TB] FAIL good_seq_gap: got %b want 0", bus.seq_gap); end
    checks++; if (bus.frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL good_frame_cnt: got %0d want 1", bus.frame_cnt); end
    idleCycles(1);
    checks++; if (bus.frame_ok !== 1'b0) begin fails++; $display("[TB] FAIL good_ok_pulse: got %b want 0", bus.frame_ok); end
    idleCycles(2);
    checks++; if (outQ.size() !== 2) begin fails++; $display("[TB] FAIL good_word_count: got %0d want 2", outQ.size()); end
    else begin
      checks++; if (outQ[0] !== {2'b10, 32'h01020304}) begin fails++; $display("[TB] FAIL good_word0: got %h want %h", outQ[0], {2'b10, 32'h01020304}); end
      checks++; if (outQ[1] !== {2'b01, 32'h05060708}) begin fails++; $display("[TB] FAIL good_word1: got %h want %h", outQ[1], {2'b01, 32'h05060708}); end
    end
  endtask

  task automatic test_seq_gap;
    outQ.delete();
    sendHeader(16'hA55A, 16'h0007, 16'h0002);
    sendPayload(8'h11, 8, 1'b1);
    idleCycles(1);
    checks++; if (bus.frame_ok !== 1'b1) begin fails++; $display("[TB] FAIL gap_frame_ok: got %b want 1", bus.frame_ok); end
    checks++; if (bus.seq_gap !== 1'b1) begin fails++; $display("[TB] FAIL gap_seq_gap: got %b want 1", bus.seq_gap); end
    checks++; if (bus.frame_cnt !== 16'd2) begin fails++; $display("[TB] FAIL gap_frame_cnt: got %0d want 2", bus.frame_cnt); end
    idleCycles(2);
    checks++; if (outQ.size() !== 2) begin fails++; $display("[TB] FAIL gap_word_count: got %0d want 2", outQ.size()); end
    else begin
      checks++; if (outQ[1] !== {2'b01, 32'h15161718}) begin fails++; $display("[TB] FAIL gap_word1: got %h want %h", outQ[1], {2'b01, 32'h15161718}); end
    end
  endtask

  task automatic test_bad_magic;
    outQ.delete();
    sendByte(8'hA5, 10'd0, 1'b0);
    sendByte(8'h5B, 10'd1, 1'b0);
    sendByte(8'h00, 10'd2, 1'b0);
    checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("[TB] FAIL magic_frame_err: got %b want 1", bus.frame_err); end
    checks++; if (bus.err_code !== 3'd1) begin fails++; $display("[TB] FAIL magic_err_code: got %0d want 1", bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd1) begin fails++; $display("[TB] FAIL magic_err_cnt: got %0d want 1", bus.err_cnt); end
    for (int i = 3; i < 10; i++) sendByte(8'(i), 10'(i), i == 9);
    idleCycles(2);
    checks++; if (outQ.size() !== 0 || bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL magic_no_words: got %0d words valid=%b want 0", outQ.size(), bus.out_valid); end
    checks++; if (bus.err_cnt !== 16'd1) begin fails++; $display("[TB] FAIL magic_err_cnt_after: got %0d want 1", bus.err_cnt); end
  endtask

  task automatic test_short;
    outQ.delete();
    sendHeader(16'hA55A, 16'h0020, 16'h0003);
    sendPayload(8'h21, 8, 1'b0);
    idleCycles(1);
    checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("[TB] FAIL short_frame_err: got %b want 1", bus.frame_err); end
    checks++; if (bus.err_code !== 3'd3) begin fails++; $display("[TB] FAIL short_err_code: got %0d want 3", bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd2) begin fails++; $display("[TB] FAIL short_err_cnt: got %0d want 2", bus.err_cnt); end
    idleCycles(2);
    checks++; if (outQ.size() !== 2) begin fails++; $display("[TB] FAIL short_word_count: got %0d want 2", outQ.size()); end
    else begin
      checks++; if (outQ[0] !== {2'b10, 32'h21222324}) begin fails++; $display("[TB] FAIL short_word0: got %h want %h", outQ[0], {2'b10, 32'h21222324}); end
      checks++; if (outQ[1] !== {2'b00, 32'h25262728}) begin fails++; $display("[TB] FAIL short_word1: got %h want %h", outQ[1], {2'b00, 32'h25262728}); end
    end
  endtask

  task automatic test_overflow;
    outQ.delete();
    bus.out_ready = 1'b0;
    sendHeader(16'hA55A, 16'h0030, 16'h0002);
    sendPayload(8'h31, 8, 1'b1);
    idleCycles(2);
    checks++; if (bus.err_code !== 3'd5) begin fails++; $display("[TB] FAIL ovf_err_code: got %0d want 5", bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd3) begin fails++; $display("[TB] FAIL ovf_err_cnt: got %0d want 3", bus.err_cnt); end
    checks++; if (bus.frame_cnt !== 16'd2) begin fails++; $display("[TB] FAIL ovf_frame_cnt: got %0d want 2", bus.frame_cnt); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h31323334 || bus.out_sof !== 1'b1) begin
      fails++; $display("[TB] FAIL ovf_held_word: got valid=%b data=%h sof=%b want 1 31323334 1", bus.out_valid, bus.out_data, bus.out_sof); end
    bus.out_ready = 1'b1;
    idleCycles(2);
    checks++; if (outQ.size() !== 1) begin fails++; $display("[TB] FAIL ovf_word_count: got %0d want 1", outQ.size()); end
    else begin
      checks++; if (outQ[0] !== {2'b10, 32'h31323334}) begin fails++; $display("[TB] FAIL ovf_word0: got %h want %h", outQ[0], {2'b10, 32'h31323334}); end
    end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL ovf_valid_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    outQ.delete();
    sendHeader(16'hA55A, 16'h0009, 16'h0002);
    sendByte(8'h41, 10'd6, 1'b0);
    sendByte(8'h42, 10'd7, 1'b0);
    sendByte(8'h43, 10'd8, 1'b0);
    sendByte(8'hA5, 10'd0, 1'b0);
    sendByte(8'h5A, 10'd1, 1'b0);
    checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("[TB] FAIL abort_frame_err: got %b want 1", bus.frame_err); end
    checks++; if (bus.err_code !== 3'd7) begin fails++; $display("[TB] FAIL abort_err_code: got %0d want 7", bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd4) begin fails++; $display("[TB] FAIL abort_err_cnt: got %0d want 4", bus.err_cnt); end
    sendByte(8'h00, 10'd2, 1'b0);
    sendByte(8'h08, 10'd3, 1'b0);
    sendByte(8'h00, 10'd4, 1'b0);
    sendByte(8'h01, 10'd5, 1'b0);
    sendPayload(8'h51, 4, 1'b1);
    idleCycles(1);
    checks++; if (bus.frame_ok !== 1'b1) begin fails++; $display("[TB] FAIL restart_frame_ok: got %b want 1", bus.frame_ok); end
    checks++; if (bus.seq_gap !== 1'b0) begin fails++; $display("[TB] FAIL restart_seq_gap: got %b want 0", bus.seq_gap); end
    checks++; if (bus.frame_cnt !== 16'd3) begin fails++; $display("[TB] FAIL restart_frame_cnt: got %0d want 3", bus.frame_cnt); end
    idleCycles(2);
    checks++; if (outQ.size() !== 1) begin fails++; $display("[TB] FAIL restart_word_count: got %0d want 1", outQ.size()); end
    else begin
      checks++; if (outQ[0] !== {2'b11, 32'h51525354}) begin fails++; $display("[TB] FAIL restart_word0: got %h want %h", outQ[0], {2'b11, 32'h51525354}); end
    end
  endtask

  task automatic test_long;
    outQ.delete();
    sendHeader(16'hA55A, 16'h0040, 16'h0001);
    for (int i = 0; i < 4; i++) sendByte(8'h71 + 8'(i), 10'(6 + i), 1'b0);
    if (CSUM_EN) sendByte(8'h04, 10'd10, 1'b0);
    sendByte(8'hEE, 10'd11, 1'b1);
    idleCycles(2);
    checks++; if (bus.err_code !== 3'd4) begin fails++; $display("[TB] FAIL long_err_code: got %0d want 4", bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd5) begin fails++; $display("[TB] FAIL long_err_cnt: got %0d want 5", bus.err_cnt); end
    checks++; if (outQ.size() !== 1) begin fails++; $display("[TB] FAIL long_word_count: got %0d want 1", outQ.size()); end
    else begin
      checks++; if (outQ[0] !== {2'b11, 32'h71727374}) begin fails++; $display("[TB] FAIL long_word0: got %h want %h", outQ[0], {2'b11, 32'h71727374}); end
    end
  endtask

  task automatic test_len_bounds;
    sendHeader(16'hA55A, 16'h0050, 16'h0000);
    sendByte(8'h00, 10'd6, 1'b1);
    checks++; if (bus.frame_err !== 1'b1 || bus.err_code !== 3'd2) begin
      fails++; $display("[TB] FAIL len_zero: got err=%b code=%0d want 1 2", bus.frame_err, bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd6) begin fails++; $display("[TB] FAIL len_zero_cnt: got %0d want 6", bus.err_cnt); end
    idleCycles(2);
    sendHeader(16'hA55A, 16'h0051, 16'h0101);
    sendByte(8'h00, 10'd6, 1'b1);
    checks++; if (bus.frame_err !== 1'b1 || bus.err_code !== 3'd2) begin
      fails++; $display("[TB] FAIL len_over: got err=%b code=%0d want 1 2", bus.frame_err, bus.err_code); end
    checks++; if (bus.err_cnt !== 16'd7) begin fails++; $display("[TB] FAIL len_over_cnt: got %0d want 7", bus.err_cnt); end
    idleCycles(2);
  endtask

`ifdef RX_CHECKSUM_EN
  task automatic test_checksum;
    sendHeader(16'hA55A, 16'h0060, 16'h0001);
    for (int i = 0; i < 4; i++) sendByte(8'h61 + 8'(i), 10'(6 + i), 1'b0);
    sendByte(8'hFB, 10'd10, 1'b1);
    idleCycles(1);
    checks++; if (bus.frame_err !== 1'b1 || bus.err_code !== 3'd6) begin
      fails++; $display("[TB] FAIL csum_err: got err=%b code=%0d want 1 6", bus.frame_err, bus.err_code); end
    checks++; if (bus.frame_cnt !== 16'd3) begin fails++; $display("[TB] FAIL csum_frame_cnt: got %0d want 3", bus.frame_cnt); end
    idleCycles(2);
  endtask
`endif

  initial begin
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rx_counter = 10'd0;
    bus.rx_last    = 1'b0;
    bus.out_ready  = 1'b1;
    $display("[TB] eth_rx_unpack bench start (checksum=%0d)", CSUM_EN);
    test_reset();
    test_good_frame();
    test_seq_gap();
    test_bad_magic();
    test_short();
    test_overflow();
    test_back_to_back();
    test_long();
    test_len_bounds();
`ifdef RX_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
